dac_serial_driver: RTL

DAC_SERIAL_DRIVER -- requirements
Module: dac_serial_driver

---
 rtl/dac_serial_driver.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/dac_serial_driver.sv
// Serialises one 8-bit sample per 16-bit DAC frame (MSB first, 4 pad bits each side) over CS_N/SCLK/DIN.
// Optional macro DAC_FRAME_CNT_EN adds a 16-bit Frame_Cnt output counting completed frames.
module dac_serial_driver #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Enable,
    input  logic [7:0]  Wave_Data,
    output logic        Sample_Ack,
    output logic        Busy,
    output logic        DAC_CS_N,
    output logic        DAC_SCLK,
    output logic        DAC_DIN
`ifdef DAC_FRAME_CNT_EN
    ,
    output logic [15:0] Frame_Cnt
`endif
);

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned BIT_W   = 4;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_div;
    logic [CNT_W-1:0]     w_div_nxt;
    logic [BIT_W-1:0]     r_bit;
    logic [BIT_W-1:0]     w_bit_nxt;
    logic                 r_sclk;
    logic                 w_sclk_nxt;
    logic [FRAME_W-1:0]   r_shift;
    logic [FRAME_W-1:0]   w_shift_nxt;
    logic                 r_din;
    logic                 r_cs_n;
    logic                 r_ack;
    logic                 r_busy;
    logic                 r_rdy;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus divider, bit counter and shifter next values
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_bit_nxt   = r_bit;
        w_sclk_nxt  = r_sclk;
        w_shift_nxt = r_shift;
        case (r_state)
            S_IDLE: begin
                if (Enable && r_rdy) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_shift_nxt = {4'b0000, Wave_Data, 4'b0000};
                w_div_nxt   = '0;
                w_bit_nxt   = '0;
                w_sclk_nxt  = 1'b0;
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (r_div != DIV_LAST) begin
                    w_div_nxt = r_div + CNT_W'(1);
                end else begin
                    w_div_nxt = '0;
                    if (!r_sclk) begin
                        w_sclk_nxt = 1'b1;
                    end else begin
                        // Falling SCLK edge: advance to the next bit; last bit ends the frame
                        w_sclk_nxt  = 1'b0;
                        w_bit_nxt   = r_bit + BIT_W'(1);
                        w_shift_nxt = {r_shift[FRAME_W-2:0], 1'b0};
                        if (r_bit == BIT_LAST) begin
                            w_state_nxt = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (r_div != GAP_LAST) begin
                    w_div_nxt = r_div + CNT_W'(1);
                end else begin
                    w_div_nxt   = '0;
                    w_state_nxt = Enable ? S_LOAD : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_div   <= '0;
            r_bit   <= '0;
            r_sclk  <= 1'b0;
            r_shift <= '0;
            r_din   <= 1'b0;
            r_cs_n  <= 1'b1;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_rdy   <= 1'b0;
        end else begin
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_sclk  <= w_sclk_nxt;
            r_shift <= w_shift_nxt;
            r_din   <= (w_state_nxt == S_SHIFT) ? w_shift_nxt[FRAME_W-1] : 1'b0;
            r_cs_n  <= !((w_state_nxt == S_LOAD) || (w_state_nxt == S_SHIFT));
            r_ack   <= (w_state_nxt == S_LOAD);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_rdy   <= 1'b1;
        end
    end

    assign Sample_Ack = r_ack;
    assign Busy       = r_busy;
    assign DAC_CS_N   = r_cs_n;
    assign DAC_SCLK   = r_sclk;
    assign DAC_DIN    = r_din;

`ifdef DAC_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;
    logic        w_frame_done;

    assign w_frame_done = (r_state == S_SHIFT) && (w_state_nxt == S_HOLD);

    // Completed-frame counter, wraps naturally at 16 bits
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_frame_cnt <= '0;
        end else if (w_frame_done) begin
            r_frame_cnt <= r_frame_cnt + 16'(1);
        end
    end

    assign Frame_Cnt = r_frame_cnt;
`endif

endmodule
